// File: rtl/dram_port_arbiter_if.sv
// dram_port_arbiter_if: bundle of core/external request lines, grant/read-return lines and the RAM port.
// Latency: none (wires only).
// Backpressure: none here; the arbiter's ack is the only flow control on the request side.
// Ports: slave = arbiter view (requests + mem_rdata in, acks/rdata/RAM controls out); master = the opposite side.
interface dram_port_arbiter_if #(
   parameter int N_REQ = 8,
   parameter int AW    = 9,
   parameter int DW    = 16
);
   logic [N_REQ-1:0]    req;
   logic [N_REQ-1:0]    we;
   logic [N_REQ*AW-1:0] addr_flat;
   logic [N_REQ*DW-1:0] wdata_flat;
   logic                ext_req;
   logic                ext_we;
   logic [AW-1:0]       ext_addr;
   logic [DW-1:0]       ext_wdata;

   logic [N_REQ-1:0]    ack;
   logic                ext_ack;
   logic [N_REQ-1:0]    rvalid;
   logic                ext_rvalid;
   logic [DW-1:0]       rdata;
   logic                busy;

   logic                mem_we;
   logic                mem_re;
   logic [AW-1:0]       mem_addr;
   logic [DW-1:0]       mem_wdata;
   logic [DW-1:0]       mem_rdata;

   modport slave (
      input  req, we, addr_flat, wdata_flat, ext_req, ext_we, ext_addr, ext_wdata, mem_rdata,
      output ack, ext_ack, rvalid, ext_rvalid, rdata, busy, mem_we, mem_re, mem_addr, mem_wdata
   );

   modport master (
      output req, we, addr_flat, wdata_flat, ext_req, ext_we, ext_addr, ext_wdata, mem_rdata,
      input  ack, ext_ack, rvalid, ext_rvalid, rdata, busy, mem_we, mem_re, mem_addr, mem_wdata
   );
endinterface

// File: rtl/dram_port_arbiter.sv
// dram_port_arbiter: round-robin share of one single-port data RAM among N_REQ cores plus an external load/dump port.
// Latency: request sampled -> ack and RAM access next cycle; read data with rvalid two cycles after the access.
// Backpressure: level req held until ack; ext port always wins; a requester acked this cycle sits out one cycle.
// Ports: clock, reset (async, active-high); bus = dram_port_arbiter_if.slave carrying requests, acks, rdata and the RAM port.
module dram_port_arbiter #(
   parameter int N_REQ = 8,
   parameter int AW    = 9,
   parameter int DW    = 16
) (
   input  logic               clock,
   input  logic               reset,
   dram_port_arbiter_if.slave bus
);
   localparam int PW = (N_REQ > 1) ? $clog2(N_REQ) : 1;

   // Issue-stage registers (visible in the issue cycle)
   logic [N_REQ-1:0] ack_q;
   logic             ext_ack_q;
   logic             mem_we_q;
   logic             mem_re_q;
   logic [AW-1:0]    mem_addr_q;
   logic [DW-1:0]    mem_wdata_q;
   logic [PW-1:0]    ptr_q;

   // Read tag travelling with the access: stage 1 rides alongside mem_re,
   // stage 2 lines up with mem_rdata being valid.
   logic             rd1_ext_q;
   logic [PW-1:0]    rd1_idx_q;
   logic             rd2_vld_q;
   logic             rd2_ext_q;
   logic [PW-1:0]    rd2_idx_q;

   // Read-return registers
   logic [N_REQ-1:0] rvalid_q;
   logic             ext_rvalid_q;
   logic [DW-1:0]    rdata_q;

   logic [N_REQ-1:0] core_elig;
   logic             ext_elig;
   logic             grant_vld;
   logic [PW-1:0]    grant_idx;
   logic [PW-1:0]    ptr_nxt;
   logic [AW-1:0]    core_addr  [N_REQ];
   logic [DW-1:0]    core_wdata [N_REQ];

   for (genvar g = 0; g < N_REQ; g++) begin : g_unpack
      assign core_addr[g]  = bus.addr_flat[g*AW +: AW];
      assign core_wdata[g] = bus.wdata_flat[g*DW +: DW];
   end

   // Index k steps above base, wrapping at N_REQ.
   function automatic logic [PW-1:0] rr_idx(input logic [PW-1:0] base, input int k);
      int s;
      s = int'(base) + k;
      if (s >= N_REQ) s = s - N_REQ;
      return PW'(s);
   endfunction

   // The requester being acked right now is still showing req (it only sees
   // the ack this cycle), so it must not be granted again off that stale level.
   assign core_elig = bus.req & ~ack_q;
   assign ext_elig  = bus.ext_req & ~ext_ack_q;

   // Walk from the farthest position down to the pointer so the last hit,
   // i.e. the first one above the pointer, is the one that sticks.
   always_comb begin
      grant_vld = 1'b0;
      grant_idx = '0;
      for (int k = N_REQ - 1; k >= 0; k--) begin
         if (core_elig[rr_idx(ptr_q, k)]) begin
            grant_vld = 1'b1;
            grant_idx = rr_idx(ptr_q, k);
         end
      end
   end

   assign ptr_nxt = (grant_idx == PW'(N_REQ - 1)) ? '0 : grant_idx + 1'b1;

   always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
         ack_q        <= '0;
         ext_ack_q    <= 1'b0;
         mem_we_q     <= 1'b0;
         mem_re_q     <= 1'b0;
         mem_addr_q   <= '0;
         mem_wdata_q  <= '0;
         ptr_q        <= '0;
         rd1_ext_q    <= 1'b0;
         rd1_idx_q    <= '0;
         rd2_vld_q    <= 1'b0;
         rd2_ext_q    <= 1'b0;
         rd2_idx_q    <= '0;
         rvalid_q     <= '0;
         ext_rvalid_q <= 1'b0;
         rdata_q      <= '0;
      end else begin
         ack_q     <= '0;
         ext_ack_q <= 1'b0;
         mem_we_q  <= 1'b0;
         mem_re_q  <= 1'b0;

         // External port outranks every core and leaves the pointer alone.
         if (ext_elig) begin
            ext_ack_q   <= 1'b1;
            mem_we_q    <= bus.ext_we;
            mem_re_q    <= ~bus.ext_we;
            mem_addr_q  <= bus.ext_addr;
            mem_wdata_q <= bus.ext_wdata;
            rd1_ext_q   <= 1'b1;
            rd1_idx_q   <= '0;
         end else if (grant_vld) begin
            ack_q[grant_idx] <= 1'b1;
            mem_we_q    <= bus.we[grant_idx];
            mem_re_q    <= ~bus.we[grant_idx];
            mem_addr_q  <= core_addr[grant_idx];
            mem_wdata_q <= core_wdata[grant_idx];
            rd1_ext_q   <= 1'b0;
            rd1_idx_q   <= grant_idx;
            ptr_q       <= ptr_nxt;
         end

         // mem_re_q doubles as the stage-1 tag valid.
         rd2_vld_q <= mem_re_q;
         rd2_ext_q <= rd1_ext_q;
         rd2_idx_q <= rd1_idx_q;

         rvalid_q     <= '0;
         ext_rvalid_q <= 1'b0;
         if (rd2_vld_q) begin
            rdata_q <= bus.mem_rdata;
            if (rd2_ext_q) ext_rvalid_q <= 1'b1;
            else           rvalid_q[rd2_idx_q] <= 1'b1;
         end
      end
   end

   assign bus.ack        = ack_q;
   assign bus.ext_ack    = ext_ack_q;
   assign bus.rvalid     = rvalid_q;
   assign bus.ext_rvalid = ext_rvalid_q;
   assign bus.rdata      = rdata_q;
   assign bus.mem_we     = mem_we_q;
   assign bus.mem_re     = mem_re_q;
   assign bus.mem_addr   = mem_addr_q;
   assign bus.mem_wdata  = mem_wdata_q;
   // Forced low in reset so a requester holding req does not show busy.
   assign bus.busy       = ~reset & ((|bus.req) | bus.ext_req | rd2_vld_q | mem_re_q);
endmodule

// File: tb/tb_dram_port_arbiter.sv
// tb_dram_port_arbiter: directed scenarios plus randomized traffic against a queue/golden-memory reference model.
// Latency: model predicts ack one cycle after req sampling and read return two cycles after issue.
// Backpressure: stimulus holds each req until the DUT acks it, with occasional early withdrawal.
module tb_dram_port_arbiter;
   localparam int N_REQ = 8;
   localparam int AW    = 9;
   localparam int DW    = 16;

   logic clock = 1'b0;
   logic reset = 1'b1;
   always #5 clock = ~clock;

   dram_port_arbiter_if #(.N_REQ(N_REQ), .AW(AW), .DW(DW)) bus ();

   dram_port_arbiter #(.N_REQ(N_REQ), .AW(AW), .DW(DW)) dut (
      .clock (clock),
      .reset (reset),
      .bus   (bus)
   );

   int checks = 0;
   int errors = 0;

   // Synchronous single-port RAM: read data valid the cycle after mem_re.
   logic [DW-1:0] ram [0:(1<<AW)-1] = '{default: '0};
   always @(posedge clock) begin
      if (bus.mem_re) bus.mem_rdata <= ram[bus.mem_addr];
      if (bus.mem_we) ram[bus.mem_addr] <= bus.mem_wdata;
   end

   // ---------------- reference model ----------------
   // Each access issued at edge n appears in cycle n; a read's data is
   // whatever the golden memory held at issue and returns at edge n+2.
   typedef struct {
      int            due;
      int            who;   // N_REQ means the external port
      logic [DW-1:0] data;
   } rd_t;

   logic [DW-1:0]    gold [0:(1<<AW)-1] = '{default: '0};
   rd_t              rq [$];
   int               m_ptr;
   int               m_cyc;
   logic [N_REQ-1:0] e_ack, e_rvalid;
   logic             e_ext_ack, e_ext_rvalid, e_mem_we, e_mem_re;
   logic [AW-1:0]    e_mem_addr;
   logic [DW-1:0]    e_mem_wdata, e_rdata;

   always @(posedge clock or posedge reset) begin : model
      int            win;
      logic          w;
      logic [AW-1:0] a;
      logic [DW-1:0] d;
      rd_t           r;
      if (reset) begin
         m_ptr = 0; m_cyc = 0;
         e_ack = '0; e_rvalid = '0; e_ext_ack = 1'b0; e_ext_rvalid = 1'b0;
         e_mem_we = 1'b0; e_mem_re = 1'b0; e_mem_addr = '0; e_mem_wdata = '0; e_rdata = '0;
         rq.delete();
      end else begin
         m_cyc++;
         win = -1;
         if (bus.ext_req && !e_ext_ack) win = N_REQ;
         else begin
            for (int k = 0; k < N_REQ; k++) begin
               if (win < 0 && bus.req[(m_ptr + k) % N_REQ] && !e_ack[(m_ptr + k) % N_REQ])
                  win = (m_ptr + k) % N_REQ;
            end
         end
         e_rvalid = '0; e_ext_rvalid = 1'b0;
         if (rq.size() > 0 && rq[0].due == m_cyc) begin
            if (rq[0].who == N_REQ) e_ext_rvalid = 1'b1;
            else                    e_rvalid[rq[0].who] = 1'b1;
            e_rdata = rq[0].data;
            void'(rq.pop_front());
         end
         e_ack = '0; e_ext_ack = 1'b0; e_mem_we = 1'b0; e_mem_re = 1'b0;
         if (win >= 0) begin
            if (win == N_REQ) begin
               w = bus.ext_we; a = bus.ext_addr; d = bus.ext_wdata; e_ext_ack = 1'b1;
            end else begin
               w = bus.we[win]; a = bus.addr_flat[win*AW +: AW]; d = bus.wdata_flat[win*DW +: DW];
               e_ack[win] = 1'b1;
               m_ptr = (win + 1) % N_REQ;
            end
            e_mem_addr = a; e_mem_wdata = d; e_mem_we = w; e_mem_re = !w;
            if (w) gold[a] = d;
            else begin
               r.due = m_cyc + 2; r.who = win; r.data = gold[a];
               rq.push_back(r);
            end
         end
      end
   end

   // ---------------- stimulus helpers ----------------
   task automatic tick();
      @(posedge clock);
      #1;
   endtask

   task automatic set_core(input int i, input logic r, input logic w,
                           input logic [AW-1:0] a, input logic [DW-1:0] d);
      bus.req[i] = r;
      bus.we[i]  = w;
      bus.addr_flat[i*AW +: AW]  = a;
      bus.wdata_flat[i*DW +: DW] = d;
   endtask

   // ---------------- scenarios ----------------
   task automatic test_reset();
      for (int i = 0; i < N_REQ; i++) set_core(i, 1'b1, 1'b1, AW'(9'h020 + i), DW'(16'h0100 + i));
      for (int c = 0; c < 3; c++) begin
         tick();
         checks++;
         if ({bus.ack, bus.ext_ack, bus.rvalid, bus.ext_rvalid, bus.mem_we, bus.mem_re,
              bus.mem_addr, bus.mem_wdata, bus.rdata, bus.busy} !== '0) begin
            errors++;
            $display("FAIL reset_outputs cyc=%0d ack=%h mem_we=%b mem_re=%b addr=%h wdata=%h rdata=%h busy=%b, all required 0",
                     c, bus.ack, bus.mem_we, bus.mem_re, bus.mem_addr, bus.mem_wdata, bus.rdata, bus.busy);
         end
      end
      reset = 1'b0;
   endtask

   task automatic test_rr_wrap();
      logic [N_REQ-1:0] exp;
      for (int k = 0; k < 9; k++) begin
         tick();
         exp = '0; exp[k % N_REQ] = 1'b1;
         checks++;
         if (bus.ack !== exp || bus.mem_we !== 1'b1 || bus.mem_addr !== AW'(9'h020 + k % N_REQ)) begin
            errors++;
            $display("FAIL rr_wrap k=%0d ack=%b we=%b addr=%h required ack=%b we=1 addr=%h",
                     k, bus.ack, bus.mem_we, bus.mem_addr, exp, 9'h020 + k % N_REQ);
         end
      end
      bus.req = '0;
      tick();
      checks++;
      if (bus.ack !== '0 || bus.mem_we !== 1'b0 || bus.mem_re !== 1'b0 || bus.mem_addr !== 9'h020) begin
         errors++;
         $display("FAIL idle_hold ack=%b we=%b re=%b addr=%h required 0/0/0 addr 020",
                  bus.ack, bus.mem_we, bus.mem_re, bus.mem_addr);
      end
   endtask

   task automatic test_write_read();
      set_core(2, 1'b1, 1'b1, 9'h010, 16'hBEEF);
      tick();
      checks++;
      if (bus.ack !== 8'b0000_0100 || bus.mem_we !== 1'b1 || bus.mem_re !== 1'b0 ||
          bus.mem_addr !== 9'h010 || bus.mem_wdata !== 16'hBEEF) begin
         errors++;
         $display("FAIL wr_issue ack=%b we=%b re=%b addr=%h wdata=%h required 00000100/1/0/010/beef",
                  bus.ack, bus.mem_we, bus.mem_re, bus.mem_addr, bus.mem_wdata);
      end
      bus.req[2] = 1'b0;
      set_core(5, 1'b1, 1'b0, 9'h010, 16'h0000);
      tick();
      checks++;
      if (bus.ack !== 8'b0010_0000 || bus.mem_re !== 1'b1 || bus.mem_we !== 1'b0 || bus.mem_addr !== 9'h010) begin
         errors++;
         $display("FAIL rd_issue ack=%b re=%b we=%b addr=%h required 00100000/1/0/010",
                  bus.ack, bus.mem_re, bus.mem_we, bus.mem_addr);
      end
      bus.req[5] = 1'b0;
      tick();
      checks++;
      if (bus.rvalid !== '0) begin
         errors++;
         $display("FAIL rd_early rvalid=%b required 0", bus.rvalid);
      end
      tick();
      checks++;
      if (bus.rvalid !== 8'b0010_0000 || bus.rdata !== 16'hBEEF) begin
         errors++;
         $display("FAIL rd_return rvalid=%b rdata=%h required 00100000 beef", bus.rvalid, bus.rdata);
      end
      tick();
      checks++;
      if (bus.rvalid !== '0 || bus.rdata !== 16'hBEEF) begin
         errors++;
         $display("FAIL rd_hold rvalid=%b rdata=%h required 0 beef", bus.rvalid, bus.rdata);
      end
   endtask

   // Pointer sits at 6 here: ext first, then core 7 before core 3 shows the
   // ext grant did not move it.
   task automatic test_ext_priority();
      bus.ext_req = 1'b1; bus.ext_we = 1'b1; bus.ext_addr = 9'h001; bus.ext_wdata = 16'h0011;
      set_core(7, 1'b1, 1'b1, 9'h002, 16'h0022);
      set_core(3, 1'b1, 1'b1, 9'h003, 16'h0033);
      tick();
      checks++;
      if (bus.ext_ack !== 1'b1 || bus.ack !== '0 || bus.mem_addr !== 9'h001 || bus.mem_wdata !== 16'h0011) begin
         errors++;
         $display("FAIL ext_first ext_ack=%b ack=%b addr=%h wdata=%h required 1/0/001/0011",
                  bus.ext_ack, bus.ack, bus.mem_addr, bus.mem_wdata);
      end
      bus.ext_req = 1'b0;
      tick();
      checks++;
      if (bus.ack !== 8'b1000_0000 || bus.ext_ack !== 1'b0) begin
         errors++;
         $display("FAIL ext_ptr_kept ack=%b ext_ack=%b required 10000000/0", bus.ack, bus.ext_ack);
      end
      bus.req[7] = 1'b0;
      tick();
      checks++;
      if (bus.ack !== 8'b0000_1000) begin
         errors++;
         $display("FAIL ext_then_core3 ack=%b required 00001000", bus.ack);
      end
      bus.req[3] = 1'b0;
      tick();
   endtask

   task automatic test_read_order();
      logic [DW-1:0] vals [3];
      vals[0] = 16'h0011; vals[1] = 16'h0022; vals[2] = 16'h0033;
      for (int i = 0; i < 3; i++) set_core(i, 1'b1, 1'b0, AW'(i + 1), 16'h0000);
      for (int c = 0; c < 6; c++) begin
         tick();
         if (c < 3) begin
            checks++;
            if (bus.ack !== N_REQ'(1 << c) || bus.mem_re !== 1'b1 || bus.mem_addr !== AW'(c + 1)) begin
               errors++;
               $display("FAIL ro_issue c=%0d ack=%b re=%b addr=%h required ack bit %0d re=1 addr=%0d",
                        c, bus.ack, bus.mem_re, bus.mem_addr, c, c + 1);
            end
            bus.req[c] = 1'b0;
         end
         if (c >= 2 && c < 5) begin
            checks++;
            if (bus.rvalid !== N_REQ'(1 << (c - 2)) || bus.rdata !== vals[c - 2]) begin
               errors++;
               $display("FAIL ro_return c=%0d rvalid=%b rdata=%h required bit %0d data %h",
                        c, bus.rvalid, bus.rdata, c - 2, vals[c - 2]);
            end
         end
         if (c == 5) begin
            checks++;
            if (bus.rvalid !== '0 || bus.rdata !== 16'h0033) begin
               errors++;
               $display("FAIL ro_hold rvalid=%b rdata=%h required 0 0033", bus.rvalid, bus.rdata);
            end
         end
      end
   endtask

   task automatic test_hold_single();
      int n_ack = 0;
      set_core(4, 1'b1, 1'b1, 9'h040, 16'h4444);
      for (int i = 0; i < 10; i++) begin
         tick();
         if (bus.ack[4]) n_ack++;
         checks++;
         if (bus.ack !== ((i % 2 == 0) ? 8'b0001_0000 : 8'b0) || (bus.mem_we && bus.mem_re)) begin
            errors++;
            $display("FAIL hold_pattern i=%0d ack=%b we=%b re=%b required ack %s, no we+re",
                     i, bus.ack, bus.mem_we, bus.mem_re, (i % 2 == 0) ? "00010000" : "0");
         end
      end
      bus.req[4] = 1'b0;
      checks++;
      if (n_ack != 5) begin
         errors++;
         $display("FAIL hold_count acks=%0d required 5", n_ack);
      end
      tick();
   endtask

   task automatic test_reset_mid_read();
      set_core(6, 1'b1, 1'b0, 9'h001, 16'h0000);
      tick();
      checks++;
      if (bus.ack !== 8'b0100_0000 || bus.mem_re !== 1'b1) begin
         errors++;
         $display("FAIL rmr_issue ack=%b re=%b required 01000000/1", bus.ack, bus.mem_re);
      end
      bus.req[6] = 1'b0;
      tick();
      reset = 1'b1;
      #1;
      checks++;
      if (bus.rvalid !== '0 || bus.rdata !== '0 || bus.busy !== 1'b0) begin
         errors++;
         $display("FAIL rmr_async rvalid=%b rdata=%h busy=%b required 0/0/0", bus.rvalid, bus.rdata, bus.busy);
      end
      tick();
      reset = 1'b0;
      for (int c = 0; c < 4; c++) begin
         tick();
         checks++;
         if (bus.rvalid !== '0 || bus.ext_rvalid !== 1'b0 || bus.rdata !== '0) begin
            errors++;
            $display("FAIL rmr_stale c=%0d rvalid=%b ext_rvalid=%b rdata=%h required 0/0/0",
                     c, bus.rvalid, bus.ext_rvalid, bus.rdata);
         end
      end
   endtask

   task automatic test_random(input int n);
      logic exp_busy;
      for (int c = 0; c < n; c++) begin
         tick();
         exp_busy = (|bus.req) | bus.ext_req | (rq.size() != 0);
         checks++;
         if (bus.ack !== e_ack || bus.ext_ack !== e_ext_ack) begin
            errors++;
            $display("FAIL rnd_ack c=%0d ack=%b ext=%b model %b %b", c, bus.ack, bus.ext_ack, e_ack, e_ext_ack);
         end
         checks++;
         if (bus.mem_we !== e_mem_we || bus.mem_re !== e_mem_re) begin
            errors++;
            $display("FAIL rnd_we_re c=%0d we=%b re=%b model %b %b", c, bus.mem_we, bus.mem_re, e_mem_we, e_mem_re);
         end
         checks++;
         if (bus.mem_addr !== e_mem_addr || bus.mem_wdata !== e_mem_wdata) begin
            errors++;
            $display("FAIL rnd_addr c=%0d addr=%h wdata=%h model %h %h", c, bus.mem_addr, bus.mem_wdata, e_mem_addr, e_mem_wdata);
         end
         checks++;
         if (bus.rvalid !== e_rvalid || bus.ext_rvalid !== e_ext_rvalid) begin
            errors++;
            $display("FAIL rnd_rvalid c=%0d rvalid=%b ext=%b model %b %b", c, bus.rvalid, bus.ext_rvalid, e_rvalid, e_ext_rvalid);
         end
         checks++;
         if (bus.rdata !== e_rdata) begin
            errors++;
            $display("FAIL rnd_rdata c=%0d rdata=%h model %h", c, bus.rdata, e_rdata);
         end
         checks++;
         if (bus.busy !== exp_busy) begin
            errors++;
            $display("FAIL rnd_busy c=%0d busy=%b model %b", c, bus.busy, exp_busy);
         end
         for (int i = 0; i < N_REQ; i++) begin
            if (bus.req[i]) begin
               if (bus.ack[i] || $urandom_range(0, 31) == 0) bus.req[i] = 1'b0;
            end else if ($urandom_range(0, 2) == 0) begin
               set_core(i, 1'b1, 1'($urandom_range(0, 1)), AW'($urandom_range(0, 15)), DW'($urandom));
            end
         end
         if (bus.ext_req) begin
            if (bus.ext_ack || $urandom_range(0, 31) == 0) bus.ext_req = 1'b0;
         end else if ($urandom_range(0, 7) == 0) begin
            bus.ext_req   = 1'b1;
            bus.ext_we    = 1'($urandom_range(0, 1));
            bus.ext_addr  = AW'($urandom_range(0, 15));
            bus.ext_wdata = DW'($urandom);
         end
      end
   endtask

   initial begin
      bus.req = '0; bus.we = '0; bus.addr_flat = '0; bus.wdata_flat = '0;
      bus.ext_req = 1'b0; bus.ext_we = 1'b0; bus.ext_addr = '0; bus.ext_wdata = '0;
      test_reset();
      test_rr_wrap();
      test_write_read();
      test_ext_priority();
      test_read_order();
      test_hold_single();
      test_reset_mid_read();
      test_random(400);
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end
endmodule

// File: doc/dram_port_arbiter.md
Name: dram_port_arbiter

Overview:
- Round-robin arbiter that shares one single-port 512x16 data RAM between N_REQ cores plus one external load/dump port.
- Sits between the cores' dram read/write/address/data outputs and the shared data RAM. Replaces the per-core-port RAM with one arbitrated port.
- Registered request-to-issue pipeline. Per-core ack pulses and read-data return.

Parameters:
- N_REQ, 8, number of core requesters.
- AW, 9, address width.
- DW, 16, data width.

Ports:
- clock  in  1  system clock, rising edge.
- reset  in  1  asynchronous, active-high reset.
- req  in  N_REQ  per-core access request; level, held until ack.
- we  in  N_REQ  per-core 1=write, 0=read; qualified by req.
- addr_flat  in  N_REQ*AW  core i address at bits [i*AW +: AW].
- wdata_flat  in  N_REQ*DW  core i write data at bits [i*DW +: DW].
- ext_req  in  1  external port request (load/dump); level.
- ext_we  in  1  external 1=write, 0=read.
- ext_addr  in  AW  external address.
- ext_wdata  in  DW  external write data.
- ack  out  N_REQ  one-hot, one-cycle pulse: core i's access issued this cycle.
- ext_ack  out  1  one-cycle pulse: external access issued.
- rvalid  out  N_REQ  one-hot, one-cycle pulse: rdata holds core i's read result.
- ext_rvalid  out  1  one-cycle pulse: rdata holds external read result.
- rdata  out  DW  registered read data, shared by all requesters.
- mem_we  out  1  RAM write enable.
- mem_re  out  1  RAM read enable.
- mem_addr  out  AW  RAM address.
- mem_wdata  out  DW  RAM write data.
- mem_rdata  in  DW  RAM read data, valid the cycle after mem_re.
- busy  out  1  high when any request is pending or a read is in flight.

Behaviour:
- Reset (async): ack, ext_ack, rvalid, ext_rvalid, mem_we, mem_re = 0. mem_addr, mem_wdata, rdata = 0. Round-robin pointer = 0. Read-tag pipeline cleared. busy = 0.
- Arbitration is combinational on cycle T-1 inputs. The winner is registered at the edge into cycle T (issue cycle).
  - In T: mem_* drive the winner's access and the winner's ack/ext_ack pulses.
- Priority: ext_req beats all cores. Otherwise the first core with eligible req, searching from pointer upward, wrapping from N_REQ-1 to 0.
- Eligibility: a requester whose ack/ext_ack is high in the current cycle is ineligible this cycle. This prevents a double grant while it drops req. Minimum spacing for the same requester is 2 cycles.
- Pointer update: after core i issues, pointer = (i+1) mod N_REQ. An external grant leaves the pointer unchanged.
- No eligible request: mem_we = mem_re = 0. mem_addr and mem_wdata hold their last values. No ack.
- Write: mem_we = 1 for the issue cycle only. No rvalid.
- Read: mem_re = 1 in T, and a requester tag is registered.
  - mem_rdata is sampled at the end of T+1.
  - rdata updates in T+2, with the matching rvalid/ext_rvalid pulse in T+2.
  - Total latency from req seen to rvalid is 3 cycles.
- Back-to-back reads from different requesters return in issue order, one per cycle. rdata holds its value between pulses.
- Requester dropping req before ack: the request is withdrawn with no side effects.
- Reset mid-read: the in-flight tag is discarded and no rvalid is produced after reset.
- busy = |req | ext_req | any in-flight read tag | mem_re.

Test Plan:
- Reset with req=8'hFF held -> all outputs 0 during reset. After release: ack issues 0,1,...,7,0 on alternating-eligibility cycles, and the pointer wraps 7->0.
- Core 2 writes addr 9'h010 data 16'hBEEF, then core 5 reads 9'h010 -> mem_we pulse with addr 0x010/data 0xBEEF. Three cycles after core 5's req: rvalid=8'b0010_0000 and rdata=16'hBEEF.
- ext_req and req[3] asserted together -> ext_ack first, ack[3] on the next eligible cycle. Pointer unchanged by the ext grant.
- Cores 0,1,2 read addrs 1,2,3 holding values 16'h0011/0022/0033 -> rvalid pulses 0,1,2 on consecutive cycles with matching rdata in issue order.
- Core 4 holds req=1 alone for 10 cycles -> ack[4] every other cycle (5 acks). No overlapping mem accesses.
- Reset asserted the cycle after a core 6 read issues -> rvalid stays 0 and rdata=0. No stale pulse after release.
